rate_timer_arbiter: RTL and testbench

Shares one programmable cycle counter among several requesters that each need a timed interval (animation step, debounce window, game tick). Requesters raise a level request with their own cycle count. The block grants the counter to one requester at a time in round-robin order and counts the interval down. It then pulses that requester's done line. It sits between the game-logic FSMs and the clock, replacing per-FSM free-running rate dividers.

---
 rtl/rate_timer_arbiter.sv | 125 ++++++++++++
 tb/tb_rate_timer_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rate_timer_arbiter.sv
// Round-robin arbiter that lends one down-counter to a set of requesters.
// The current owner gets a done pulse when its programmed interval expires.
module rate_timer_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int IDW     = 2
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] cycles,
  output logic [NUM_REQ-1:0]       grant,
  output logic [IDW-1:0]           active_id,
  output logic                     busy,
  output logic [NUM_REQ-1:0]       done,
  output logic [1:0]               dbg_state
);

  // Handshake: req[i] is a level that must stay high for the whole interval.
  // grant[i] acknowledges it, and done[i] pulses for one cycle while grant[i]
  // is still high. Dropping req[i] while it is granted abandons the interval.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] done_q;
  logic [IDW-1:0]     active_id_q;
  logic [IDW-1:0]     ptr_q;
  logic               busy_q;
  logic [WIDTH-1:0]   count_q;

  logic               win_found;
  logic [IDW-1:0]     win_idx;
  logic [IDW:0]       cand;
  logic [WIDTH-1:0]   win_cycles;
  logic [WIDTH-1:0]   win_load;
  logic [IDW-1:0]     ptr_d;
  logic               owner_req;

  // The scan starts at ptr and wraps, so the lowest set index at or above ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NUM_REQ)) begin
        cand = cand - (IDW+1)'(NUM_REQ);
      end
      if (!win_found && req[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDW-1:0];
      end
    end
  end

  assign win_cycles = cycles[int'(win_idx)*WIDTH +: WIDTH];
  // A zero interval loads as one, so the counter can never wrap.
  assign win_load   = (win_cycles == '0) ? WIDTH'(1) : win_cycles;
  assign ptr_d      = (win_idx == IDW'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
  assign owner_req  = req[active_id_q];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      done_q      <= '0;
      active_id_q <= '0;
      ptr_q       <= '0;
      busy_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            state_q     <= S_COUNT;
            grant_q     <= NUM_REQ'(1) << win_idx;
            active_id_q <= win_idx;
            count_q     <= win_load;
            ptr_q       <= ptr_d;
            busy_q      <= 1'b1;
          end
        end
        S_COUNT: begin
          // An abort wins over expiry in the same cycle, and it leaves ptr untouched.
          if (!owner_req) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            active_id_q <= '0;
            busy_q      <= 1'b0;
          end else if (count_q == WIDTH'(1)) begin
            state_q <= S_DONE;
            done_q  <= grant_q;
          end else begin
            count_q <= count_q - WIDTH'(1);
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          grant_q     <= '0;
          active_id_q <= '0;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q     <= S_IDLE;
          grant_q     <= '0;
          active_id_q <= '0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign grant     = grant_q;
  assign active_id = active_id_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rate_timer_arbiter.sv
// Bench for rate_timer_arbiter: a model predicts ownership records and a
// monitor compares each observed ownership (grant rise to fall) against them.
module tb_rate_timer_arbiter;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 32;
  localparam int IDW     = 2;
  localparam int RW      = 73;

  logic                     clock  = 1'b0;
  logic                     resetn = 1'b0;
  logic [NUM_REQ-1:0]       req    = '0;
  logic [NUM_REQ*WIDTH-1:0] cycles = '0;
  logic [NUM_REQ-1:0]       grant;
  logic [IDW-1:0]           active_id;
  logic                     busy;
  logic [NUM_REQ-1:0]       done;
  logic [1:0]               dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  // Record: {id[8], start edge[32], cycles granted[32], aborted[1]}
  logic [RW-1:0] exp_q[$];

  always #5 clock = ~clock;

  rate_timer_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clock(clock), .resetn(resetn), .req(req), .cycles(cycles),
    .grant(grant), .active_id(active_id), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  task automatic check(input string name, input longint act, input longint exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic int oh_idx(input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Reference model: edges are numbered from 1. Ownership that starts at edge S
  // with interval N lasts N+1 cycles with done on its last one, and the next
  // grant may start no earlier than edge S+N+2. An abort seen at edge E ends
  // ownership after E, and arbitration resumes at E+1.
  int m_own = -1, m_start = 0, m_len = 0, m_free = 0, m_ptr = 0;
  always @(posedge clock) begin
    cyc = cyc + 1;
    if (!resetn) begin
      m_own = -1; m_ptr = 0; m_free = 0;
    end else if (m_own >= 0) begin
      if (!req[m_own]) begin
        exp_q.push_back({8'(m_own), 32'(m_start), 32'(cyc - m_start), 1'b1});
        m_own  = -1;
        m_free = cyc + 1;
      end else if (cyc == m_start + m_len) begin
        exp_q.push_back({8'(m_own), 32'(m_start), 32'(m_len + 1), 1'b0});
        m_own  = -1;
        m_free = cyc + 2;
      end
    end else if (cyc >= m_free && req != '0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NUM_REQ;
        if (m_own < 0 && req[idx]) m_own = idx;
      end
      m_start = cyc;
      m_len   = int'(cycles[m_own*WIDTH +: WIDTH]);
      if (m_len == 0) m_len = 1;
      m_ptr = (m_own + 1) % NUM_REQ;
    end
  end

  // Monitor: samples at the falling edge, checks invariants, tracks ownerships.
  logic [NUM_REQ-1:0] mon_grant = '0;
  bit mon_active = 0;
  int mon_start, mon_len, mon_done_cnt, mon_done_pos;
  always @(negedge clock) begin
    if (!resetn) begin
      mon_active = 0;
    end else begin
      check("busy_vs_grant", busy, grant != '0);
      check("grant_onehot0", $onehot0(grant), 1);
      check("active_id", active_id, oh_idx(grant));
      check("done_subset", (done == '0) || (done == grant), 1);
      check("state_vs_busy", dbg_state == 2'd0, !busy);
      if (mon_active && grant != mon_grant) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_ownership: got id %0d start %0d len %0d expected none",
                   oh_idx(mon_grant), mon_start, mon_len);
        end else begin
          logic [RW-1:0] r;
          r = exp_q.pop_front();
          check("owner_id", oh_idx(mon_grant), r[72:65]);
          check("owner_start", mon_start, r[64:33]);
          check("owner_len", mon_len, r[32:1]);
          check("done_pulses", mon_done_cnt, r[0] ? 0 : 1);
          if (!r[0]) check("done_position", mon_done_pos, mon_len);
        end
        mon_active = 0;
      end
      if (!mon_active && grant != '0) begin
        mon_active = 1; mon_grant = grant; mon_start = cyc;
        mon_len = 0; mon_done_cnt = 0; mon_done_pos = 0;
      end
      if (mon_active) begin
        mon_len++;
        if (done != '0) begin mon_done_cnt++; mon_done_pos = mon_len; end
      end
    end
  end

  task automatic drive(input logic [NUM_REQ-1:0] r);
    @(negedge clock); #1;
    req = r;
  endtask

  task automatic set_cyc(input int i, input int v);
    cycles[i*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset(input logic [NUM_REQ-1:0] r_after);
    @(negedge clock); #2;
    resetn = 1'b0;
    #1;
    check("async_reset_outputs", {grant, done, busy, active_id}, 0);
    exp_q.delete();
    req = r_after;
    repeat (2) @(negedge clock);
    #2 resetn = 1'b1;
  endtask

  initial begin
    #1;
    check("reset_outputs", {grant, done, busy, active_id, dbg_state}, 0);
    wait_cycles(2);
    #2 resetn = 1'b1;

    // Single request, interval 5
    set_cyc(0, 5);
    drive(4'b0001); wait_cycles(8);
    drive(4'b0000); wait_cycles(10);

    // Zero and one intervals
    set_cyc(0, 0);
    drive(4'b0001); wait_cycles(2);
    drive(4'b0000); wait_cycles(4);
    set_cyc(0, 1);
    drive(4'b0001); wait_cycles(2);
    drive(4'b0000); wait_cycles(4);

    // Round-robin with all requesters held
    for (int i = 0; i < NUM_REQ; i++) set_cyc(i, 3);
    drive(4'b1111); wait_cycles(26);
    drive(4'b0000); wait_cycles(8);

    // Abort mid-count, then a normal grant
    set_cyc(1, 100);
    drive(4'b0010); wait_cycles(11);
    drive(4'b0000); wait_cycles(3);
    set_cyc(2, 2);
    drive(4'b0100); wait_cycles(4);
    drive(4'b0000); wait_cycles(4);

    // Interval latched at load; pointer wraps after requester 3
    set_cyc(3, 4);
    set_cyc(0, 2);
    drive(4'b1000); wait_cycles(2);
    set_cyc(3, 50);
    drive(4'b1001); wait_cycles(12);
    drive(4'b0000); wait_cycles(6);

    // Asynchronous reset mid-count, pointer returns to 0
    set_cyc(0, 20);
    drive(4'b0001); wait_cycles(5);
    do_reset(4'b1100);
    wait_cycles(12);
    drive(4'b0000); wait_cycles(6);

    // Randomized traffic
    for (int it = 0; it < 500; it++) begin
      @(negedge clock); #1;
      if ($urandom_range(0, 3) == 0) req = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
      for (int i = 0; i < NUM_REQ; i++)
        if ($urandom_range(0, 7) == 0) set_cyc(i, $urandom_range(0, 6));
      if ($urandom_range(0, 149) == 0) do_reset(NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1)));
    end

    // Drain
    drive(4'b0000);
    for (int i = 0; i < 200 && busy; i++) @(negedge clock);
    check("drain_idle", busy, 0);
    wait_cycles(3);
    check("pending_records", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
